// File: rtl/flash_pattern_seq.sv
// Flash pattern sequencer: writes seed+i to base+i for count bytes,
// then optionally reads back and counts mismatches.
module flash_pattern_seq #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit VERIFY         = 1'b1
) (
  input  logic       CLK_50MHZ,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] count,
  input  logic [7:0] seed,
  output logic [7:0] addr,
  output logic [7:0] data,
  input  logic [7:0] data_rd,
  output logic       direction_rw,
  output logic       do_rw,
  input  logic       done,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       timeout,
  output logic [7:0] err_count,
  output logic [7:0] first_err_addr
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDW-1:0] WD_MAX =
    WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     base_q, last_q, seed_q, idx_q;
  logic [WDW-1:0] wd_q;
  logic           pass_q, fail_q, to_q;
  logic [7:0]     err_q, ferr_q;

  logic in_req, wd_exp, at_last, mismatch, gap_fin;

  assign in_req   = (state_q == WR_REQ) ||
                    (state_q == RD_REQ);
  assign wd_exp   = (wd_q == WD_MAX);
  assign at_last  = (idx_q == last_q);
  assign addr     = base_q + idx_q;
  assign data     = seed_q + idx_q;
  assign mismatch = (data_rd != data);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) state_d = WR_REQ;
      WR_REQ:
        if (done)        state_d = WR_GAP;
        else if (wd_exp) state_d = FINISH;
      WR_GAP:
        if (!at_last)    state_d = WR_REQ;
        else if (VERIFY) state_d = RD_REQ;
        else             state_d = FINISH;
      RD_REQ:
        if (done)        state_d = RD_GAP;
        else if (wd_exp) state_d = FINISH;
      RD_GAP:
        if (at_last) state_d = FINISH;
        else         state_d = RD_REQ;
      FINISH:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Normal completion out of a gap state; timeouts set flags directly
  assign gap_fin = (state_d == FINISH) &&
                   ((state_q == WR_GAP) ||
                    (state_q == RD_GAP));

  always_comb begin
    do_rw        = in_req;
    direction_rw = (state_q == RD_REQ) ||
                   (state_q == RD_GAP);
    busy         = (state_q != IDLE) &&
                   (state_q != FINISH);
  end

  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = to_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      last_q  <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            last_q <= count - 8'd1;
            seed_q <= seed;
            idx_q  <= '0;
            wd_q   <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            to_q   <= 1'b0;
            err_q  <= '0;
            ferr_q <= '0;
          end
        end
        WR_REQ, RD_REQ: begin
          if (done) begin
            wd_q <= '0;
            if (state_q == RD_REQ && mismatch) begin
              if (err_q == 8'd0)  ferr_q <= addr;
              if (err_q != 8'hFF) err_q  <= err_q + 8'd1;
            end
          end else if (wd_exp) begin
            wd_q   <= '0;
            to_q   <= 1'b1;
            fail_q <= 1'b1;
            pass_q <= 1'b0;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        WR_GAP, RD_GAP: begin
          if (at_last) idx_q <= '0;
          else         idx_q <= idx_q + 8'd1;
        end
        default: ;
      endcase
      if (gap_fin) begin
        pass_q <= (err_q == 8'd0) && !to_q;
        fail_q <= (err_q != 8'd0) || to_q;
      end
    end
  end

endmodule

// File: tb/tb_flash_pattern_seq.sv
// Bench for flash_pattern_seq: verify instance (k=0) and
// write-only instance (k=1), each with a small flash model.
module tb_flash_pattern_seq;

  localparam int DLY = 10;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [1:0]      rst_s, start_s, dir_s, do_s, done_s;
  logic [1:0]      busy_s, pass_s, fail_s, to_s;
  logic [1:0][7:0] base_s, cnt_s, seed_s;
  logic [1:0][7:0] addr_s, data_s, rd_s, err_s, ferr_s;

  flash_pattern_seq #(.TIMEOUT_CYCLES(16), .VERIFY(1'b1)) u0 (
    .CLK_50MHZ(clk), .rst(rst_s[0]), .start(start_s[0]),
    .base_addr(base_s[0]), .count(cnt_s[0]), .seed(seed_s[0]),
    .addr(addr_s[0]), .data(data_s[0]), .data_rd(rd_s[0]),
    .direction_rw(dir_s[0]), .do_rw(do_s[0]), .done(done_s[0]),
    .busy(busy_s[0]), .pass(pass_s[0]), .fail(fail_s[0]),
    .timeout(to_s[0]), .err_count(err_s[0]),
    .first_err_addr(ferr_s[0]));

  flash_pattern_seq #(.TIMEOUT_CYCLES(16), .VERIFY(1'b0)) u1 (
    .CLK_50MHZ(clk), .rst(rst_s[1]), .start(start_s[1]),
    .base_addr(base_s[1]), .count(cnt_s[1]), .seed(seed_s[1]),
    .addr(addr_s[1]), .data(data_s[1]), .data_rd(rd_s[1]),
    .direction_rw(dir_s[1]), .do_rw(do_s[1]), .done(done_s[1]),
    .busy(busy_s[1]), .pass(pass_s[1]), .fail(fail_s[1]),
    .timeout(to_s[1]), .err_count(err_s[1]),
    .first_err_addr(ferr_s[1]));

  // flash model state and bench-side knobs
  logic [7:0] mem [2][256];
  int         mcnt [2];
  logic [1:0] nodone, corrupt_en, mon_clr;
  logic [1:0][7:0] corrupt_addr, exp_base, exp_seed;

  // monitor counters
  int n_wr [2], n_rd [2], bad_acc [2], gap_bad [2];
  int unstable [2], gcnt [2], cur_hi [2], max_hi [2];
  logic [1:0] prev_do, prev_dir;
  logic [1:0][7:0] prev_addr, prev_data;

  always_comb begin
    rd_s = '0;
    for (int k = 0; k < 2; k++) begin
      rd_s[k] = mem[k][addr_s[k]] ^
        ((corrupt_en[k] && addr_s[k] == corrupt_addr[k]) ?
         8'h5A : 8'h00);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (do_s[k] && !done_s[k] && !nodone[k]) begin
        if (mcnt[k] == DLY - 1) begin
          done_s[k] <= 1'b1;
          mcnt[k]   <= 0;
          if (!dir_s[k]) mem[k][addr_s[k]] <= data_s[k];
        end else begin
          mcnt[k] <= mcnt[k] + 1;
        end
      end else begin
        done_s[k] <= 1'b0;
        mcnt[k]   <= 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mon_clr[k]) begin
        n_wr[k] <= 0; n_rd[k] <= 0; bad_acc[k] <= 0;
        gap_bad[k] <= 0; unstable[k] <= 0; gcnt[k] <= 0;
        cur_hi[k] <= 0; max_hi[k] <= 0;
      end else begin
        if (do_s[k] && done_s[k]) begin
          if (dir_s[k]) begin
            n_rd[k] <= n_rd[k] + 1;
            if (addr_s[k] != 8'(exp_base[k] + n_rd[k]) ||
                data_s[k] != 8'(exp_seed[k] + n_rd[k]))
              bad_acc[k] <= bad_acc[k] + 1;
          end else begin
            n_wr[k] <= n_wr[k] + 1;
            if (addr_s[k] != 8'(exp_base[k] + n_wr[k]) ||
                data_s[k] != 8'(exp_seed[k] + n_wr[k]))
              bad_acc[k] <= bad_acc[k] + 1;
          end
        end
        if (do_s[k] && !prev_do[k]) begin
          if (n_wr[k] + n_rd[k] > 0 && gcnt[k] != 1)
            gap_bad[k] <= gap_bad[k] + 1;
          gcnt[k] <= 0;
        end else if (!do_s[k] && busy_s[k]) begin
          gcnt[k] <= gcnt[k] + 1;
        end
        if (do_s[k] && prev_do[k] &&
            (addr_s[k] != prev_addr[k] ||
             data_s[k] != prev_data[k] ||
             dir_s[k] != prev_dir[k]))
          unstable[k] <= unstable[k] + 1;
        if (do_s[k]) begin
          cur_hi[k] <= cur_hi[k] + 1;
          if (cur_hi[k] + 1 > max_hi[k])
            max_hi[k] <= cur_hi[k] + 1;
        end else begin
          cur_hi[k] <= 0;
        end
      end
      prev_do[k]   <= do_s[k];
      prev_dir[k]  <= dir_s[k];
      prev_addr[k] <= addr_s[k];
      prev_data[k] <= data_s[k];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_seq(input int k, input logic [7:0] b,
                           input logic [7:0] c,
                           input logic [7:0] s);
    exp_base[k] = b;
    exp_seed[k] = s;
    mon_clr[k]  = 1'b1;
    tick(1);
    mon_clr[k]  = 1'b0;
    base_s[k]   = b;
    cnt_s[k]    = c;
    seed_s[k]   = s;
    start_s[k]  = 1'b1;
    tick(1);
    start_s[k]  = 1'b0;
    check("busy_after_start", int'(busy_s[k]), 1);
  endtask

  task automatic wait_idle(input int k);
    int c = 0;
    while (busy_s[k] && c < 20000) begin
      tick(1);
      c++;
    end
    check("finish_in_budget", int'(c < 20000), 1);
  endtask

  typedef struct {
    logic [7:0] base;
    logic [7:0] cnt;
    logic [7:0] seed;
    bit         cor;
    logic [7:0] cor_off;
    int         e_err;
    int         e_ferr;
    int         e_pass;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{8'h35, 8'd1, 8'hC9, 1'b0, 8'd0, 0, 8'h00, 1};
    vecs[1] = '{8'hFE, 8'd4, 8'h00, 1'b0, 8'd0, 0, 8'h00, 1};
    vecs[2] = '{8'h10, 8'd3, 8'h40, 1'b1, 8'd1, 1, 8'h11, 0};
    vecs[3] = '{8'h80, 8'd5, 8'hFF, 1'b1, 8'd4, 1, 8'h84, 0};

    rst_s = 2'b11; start_s = '0; base_s = '0; cnt_s = '0;
    seed_s = '0; nodone = '0; corrupt_en = '0;
    corrupt_addr = '0; exp_base = '0; exp_seed = '0;
    mon_clr = 2'b11;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = 8'h00;
    tick(3);
    rst_s = 2'b00;
    mon_clr = 2'b00;

    check("rst_do_rw", int'(do_s[0]), 0);
    check("rst_busy", int'(busy_s[0]), 0);
    check("rst_pass", int'(pass_s[0]), 0);
    check("rst_fail", int'(fail_s[0]), 0);
    check("rst_addr", int'(addr_s[0]), 0);
    check("rst_err", int'(err_s[0]), 0);

    for (int i = 0; i < 4; i++) begin
      corrupt_en[0]   = vecs[i].cor;
      corrupt_addr[0] = vecs[i].base + vecs[i].cor_off;
      start_seq(0, vecs[i].base, vecs[i].cnt, vecs[i].seed);
      wait_idle(0);
      tick(1);
      check("v_pass", int'(pass_s[0]), vecs[i].e_pass);
      check("v_fail", int'(fail_s[0]), 1 - vecs[i].e_pass);
      check("v_timeout", int'(to_s[0]), 0);
      check("v_err", int'(err_s[0]), vecs[i].e_err);
      check("v_ferr", int'(ferr_s[0]), vecs[i].e_ferr);
      check("v_nwr", n_wr[0], int'(vecs[i].cnt));
      check("v_nrd", n_rd[0], int'(vecs[i].cnt));
      check("v_acc", bad_acc[0], 0);
      check("v_gap", gap_bad[0], 0);
      check("v_stable", unstable[0], 0);
    end
    corrupt_en[0] = 1'b0;

    nodone[0] = 1'b1;
    start_seq(0, 8'h40, 8'd2, 8'h01);
    wait_idle(0);
    check("to_hi_cycles", max_hi[0], 16);
    check("to_timeout", int'(to_s[0]), 1);
    check("to_fail", int'(fail_s[0]), 1);
    check("to_pass", int'(pass_s[0]), 0);
    check("to_busy", int'(busy_s[0]), 0);
    check("to_do_rw", int'(do_s[0]), 0);
    nodone[0] = 1'b0;
    tick(2);

    start_seq(0, 8'h20, 8'd5, 8'h07);
    begin
      int c = 0;
      while (!(n_wr[0] == 2 && do_s[0]) && c < 2000) begin
        tick(1);
        c++;
      end
      check("reach_3rd_write", int'(c < 2000), 1);
    end
    rst_s[0] = 1'b1;
    start_s[0] = 1'b1;
    tick(1);
    rst_s[0] = 1'b0;
    start_s[0] = 1'b0;
    check("mid_rst_do_rw", int'(do_s[0]), 0);
    check("mid_rst_busy", int'(busy_s[0]), 0);
    check("mid_rst_flags",
          int'({pass_s[0], fail_s[0], to_s[0]}), 0);
    check("mid_rst_addr", int'(addr_s[0]), 0);
    tick(2);
    check("mid_rst_idle", int'(busy_s[0]), 0);
    start_seq(0, 8'hA0, 8'd3, 8'h55);
    wait_idle(0);
    tick(1);
    check("post_rst_pass", int'(pass_s[0]), 1);
    check("post_rst_nrd", n_rd[0], 3);
    check("post_rst_acc", bad_acc[0], 0);

    start_seq(1, 8'h9C, 8'd0, 8'h33);
    tick(5);
    base_s[1] = 8'h00; cnt_s[1] = 8'd1; seed_s[1] = 8'hEE;
    start_s[1] = 1'b1;
    tick(1);
    start_s[1] = 1'b0;
    wait_idle(1);
    tick(1);
    check("nv_nwr", n_wr[1], 256);
    check("nv_nrd", n_rd[1], 0);
    check("nv_acc", bad_acc[1], 0);
    check("nv_gap", gap_bad[1], 0);
    check("nv_pass", int'(pass_s[1]), 1);
    check("nv_fail", int'(fail_s[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
